// File: rtl/mem_loader.sv
// Byte-stream memory loader: parses a length-prefixed stream of 16-bit words,
// writes each word to consecutive addresses and verifies a trailing XOR checksum.
module mem_loader #(
    parameter int unsigned WIDTH     = 13,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        write_enable,
    output logic [15:0] write_address,
    output logic [15:0] data_in,
    output logic        busy,
    output logic        load_ok,
    output logic        load_err
);

    localparam logic [15:0] ADDR_MASK = 16'((17'd1 << WIDTH) - 17'd1);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StCheck,
        StDone
    } state_e;

    state_e      r_state, w_state;
    logic [15:0] r_count, w_count;
    logic [15:0] r_index, w_index;
    logic [7:0]  r_csum, w_csum;
    logic [7:0]  r_hi, w_hi;
    logic        r_we, w_we;
    logic [15:0] r_addr, w_addr;
    logic [15:0] r_data, w_data;
    logic        r_ok, w_ok;
    logic        r_err, w_err;
    logic        w_session;
    logic        w_accept;
    logic [15:0] w_index_inc;

    // Ready depends on state only, so there is no path from byte_valid.
    assign w_session   = (r_state != StIdle) && (r_state != StDone);
    assign w_accept    = w_session && byte_valid;
    assign w_index_inc = r_index + 16'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_index <= '0;
            r_csum  <= '0;
            r_hi    <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_count;
            r_index <= w_index;
            r_csum  <= w_csum;
            r_hi    <= w_hi;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_ok    <= w_ok;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_state = r_state;
        w_count = r_count;
        w_index = r_index;
        w_csum  = r_csum;
        w_hi    = r_hi;
        w_we    = 1'b0;
        w_addr  = r_addr;
        w_data  = r_data;
        w_ok    = r_ok;
        w_err   = r_err;
        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state = StLenHi;
                    w_ok    = 1'b0;
                    w_err   = 1'b0;
                    w_index = '0;
                    w_csum  = '0;
                end
            end
            StLenHi: begin
                if (w_accept) begin
                    w_count[15:8] = byte_in;
                    w_csum        = r_csum ^ byte_in;
                    w_state       = StLenLo;
                end
            end
            StLenLo: begin
                if (w_accept) begin
                    w_count[7:0] = byte_in;
                    w_csum       = r_csum ^ byte_in;
                    w_state      = ({r_count[15:8], byte_in} == 16'd0) ? StCheck : StDataHi;
                end
            end
            StDataHi: begin
                if (w_accept) begin
                    w_hi    = byte_in;
                    w_csum  = r_csum ^ byte_in;
                    w_state = StDataLo;
                end
            end
            StDataLo: begin
                if (w_accept) begin
                    // Registered here so the strobe appears the cycle after the accept.
                    w_we    = 1'b1;
                    w_data  = {r_hi, byte_in};
                    w_addr  = (BASE_ADDR + r_index) & ADDR_MASK;
                    w_index = w_index_inc;
                    w_csum  = r_csum ^ byte_in;
                    w_state = (w_index_inc == r_count) ? StCheck : StDataHi;
                end
            end
            StCheck: begin
                if (w_accept) begin
                    if (byte_in == r_csum) begin
                        w_ok = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                    w_state = StDone;
                end
            end
            default: w_state = StIdle;
        endcase
    end

    assign byte_ready    = w_session;
    assign busy          = w_session;
    assign write_enable  = r_we;
    assign write_address = r_addr;
    assign data_in       = r_data;
    assign load_ok       = r_ok;
    assign load_err      = r_err;

endmodule
